// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexes a 32-bit hex value onto an 8-digit common-select 7-segment display.
// Latency: outputs are registered one cycle behind the scan counters; new values appear from the next frame.
// Backpressure: in_ready drops while a value is pending and rises the cycle after it is committed at a frame boundary.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 10000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic [7:0]  dig_en,
    input  logic        lz_blank,
    output logic [7:0]  num_csn,
    output logic [6:0]  num_a_g,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0] div_cnt;
    logic [2:0]    dig_idx;
    logic [31:0]   disp_reg;
    logic [31:0]   pend_reg;
    logic          pend_full;

    logic          slot_end;
    logic          frame_end;
    logic          hi_zero;
    logic          digit_vis;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic [7:0]    csn_nxt;
    logic [6:0]    seg_nxt;

    assign in_ready  = ~pend_full;
    assign slot_end  = (div_cnt == DIV_MAX);
    assign frame_end = slot_end && (dig_idx == 3'd7);
    assign nib       = disp_reg[{dig_idx, 2'b00} +: 4];

    // Slot divider and digit index; the index advances on the last cycle of each slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            dig_idx <= 3'd0;
        end else if (slot_end) begin
            div_cnt <= '0;
            dig_idx <= dig_idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Pending buffer: accept when empty, commit to the display only at the frame boundary.
    // While full, in_ready is low, so accept and commit can never happen on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            disp_reg  <= 32'h0;
            pend_reg  <= 32'h0;
            pend_full <= 1'b0;
        end else if (frame_end && pend_full) begin
            disp_reg  <= pend_reg;
            pend_full <= 1'b0;
        end else if (in_valid && !pend_full) begin
            pend_reg  <= in_data;
            pend_full <= 1'b1;
        end
    end

    // Leading-zero test: are nibbles dig_idx..7 all zero?
    always_comb begin
        hi_zero = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k >= int'(dig_idx) && disp_reg[4*k +: 4] != 4'h0) begin
                hi_zero = 1'b0;
            end
        end
    end

    assign digit_vis = dig_en[dig_idx] && !(lz_blank && (dig_idx != 3'd0) && hi_zero);

    // Hex to segment decode, bit6 = a down to bit0 = g.
    always_comb begin
        seg_dec = 7'h00;
        case (nib)
            4'h0: seg_dec = 7'h7E;
            4'h1: seg_dec = 7'h30;
            4'h2: seg_dec = 7'h6D;
            4'h3: seg_dec = 7'h79;
            4'h4: seg_dec = 7'h33;
            4'h5: seg_dec = 7'h5B;
            4'h6: seg_dec = 7'h5F;
            4'h7: seg_dec = 7'h70;
            4'h8: seg_dec = 7'h7F;
            4'h9: seg_dec = 7'h7B;
            4'hA: seg_dec = 7'h77;
            4'hB: seg_dec = 7'h1F;
            4'hC: seg_dec = 7'h4E;
            4'hD: seg_dec = 7'h3D;
            4'hE: seg_dec = 7'h4F;
            4'hF: seg_dec = 7'h47;
            default: seg_dec = 7'h00;
        endcase
    end

    // Pin values for the current slot: dark during the blanking window or for hidden digits.
    always_comb begin
        csn_nxt = 8'hFF;
        seg_nxt = 7'h00;
        if (div_cnt >= BLANK_END && digit_vis) begin
            csn_nxt = ~(8'd1 << dig_idx);
            seg_nxt = seg_dec;
        end
    end

    // Registered board outputs and end-of-frame pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num_csn    <= 8'hFF;
            num_a_g    <= 7'h00;
            frame_done <= 1'b0;
        end else begin
            num_csn    <= csn_nxt;
            num_a_g    <= seg_nxt;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = SCAN_DIV * 8;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [7:0]  dig_en;
    logic        lz_blank;
    logic [7:0]  num_csn;
    logic [6:0]  num_a_g;
    logic        frame_done;

    seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .dig_en     (dig_en),
        .lz_blank   (lz_blank),
        .num_csn    (num_csn),
        .num_a_g    (num_a_g),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: a single position within the frame plus the shown and pending values.
    int          m_pos;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    logic        m_pend_full;
    logic [7:0]  m_csn;
    logic [6:0]  m_seg;
    logic        m_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos       = 0;
        m_disp      = 32'h0;
        m_pend      = 32'h0;
        m_pend_full = 1'b0;
        m_csn       = 8'hFF;
        m_seg       = 7'h00;
        m_fd        = 1'b0;
    endtask

    task automatic model_edge();
        int          slot;
        int          ph;
        logic [31:0] upper;
        logic        vis;
        logic        rdy;
        slot  = m_pos / SCAN_DIV;
        ph    = m_pos % SCAN_DIV;
        upper = m_disp >> (4 * slot);
        vis   = dig_en[slot] && !(lz_blank && slot != 0 && upper == 32'h0);
        m_fd  = (m_pos == FRAME - 1);
        if (ph < BLANK_CYC || !vis) begin
            m_csn = 8'hFF;
            m_seg = 7'h00;
        end else begin
            m_csn = ~(8'd1 << slot);
            m_seg = hex_tab[upper & 32'hF];
        end
        rdy = !m_pend_full;
        if (m_fd && m_pend_full) begin
            m_disp      = m_pend;
            m_pend_full = 1'b0;
        end
        if (in_valid && rdy) begin
            m_pend      = in_data;
            m_pend_full = 1'b1;
        end
        m_pos = (m_pos + 1) % FRAME;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("num_csn", num_csn, m_csn);
        chk("num_a_g", num_a_g, m_seg);
        chk("frame_done", frame_done, m_fd);
        chk("in_ready", in_ready, !m_pend_full);
        chk("one_digit", $countones(~num_csn) <= 1, 1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called just after a falling edge: asserts reset between edges to prove it acts asynchronously.
    task automatic do_reset();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_csn", num_csn, 8'hFF);
        chk("rst_a_g", num_a_g, 7'h00);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic align(input int p);
        for (int i = 0; i < FRAME && m_pos != p; i++) step();
    endtask

    task automatic offer_once(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        dig_en   = 8'hFF;
        lz_blank = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle: all digits show 0
        run(70);

        // Single value accepted mid-frame, shown from the next frame
        align(10);
        offer_once(32'h0000_0007);
        run(70);

        // Back-to-back offers: 1, then D held valid
        align(12);
        in_valid = 1'b1;
        in_data  = 32'h1;
        step();
        in_data  = 32'hD;
        run(80);
        in_valid = 1'b0;
        run(10);

        // Leading-zero suppression on and off
        offer_once(32'h0000_0F06);
        lz_blank = 1'b1;
        run(70);
        lz_blank = 1'b0;
        run(40);

        // Digit mask
        dig_en = 8'b0000_0101;
        offer_once(32'h8888_8888);
        run(80);
        dig_en = 8'hFF;

        // Reset mid-frame with a value pending
        align(4);
        offer_once(32'h5555_5555);
        step();
        chk("pend_before_rst", in_ready, 1'b0);
        do_reset();
        run(70);

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            if (i % 50 == 0) begin
                dig_en   = 8'($urandom);
                lz_blank = 1'($urandom);
            end
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
            step();
            if (i == 600) begin
                do_reset();
            end
        end
        in_valid = 1'b0;
        run(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
